dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the DDR2 data-port arbiter.
//   state_e   : arbiter FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   grant_e   : which requester owns the port (LOADER/CORE)
//   TMO_DATA  : load data returned to the core when an access times out
//   MEM_READ / MEM_WRITE : memory_read_or_write polarity used by cache_memory
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_LOADER = 1'b0,
    GRANT_CORE   = 1'b1
  } grant_e;

  localparam logic [31:0] TMO_DATA  = 32'hDEADBEEF;

  localparam logic        MEM_READ  = 1'b1;
  localparam logic        MEM_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
//   req[0]     : loader request (already qualified for eligibility)
//   req[1]     : core request   (already qualified for eligibility)
//   last_grant : owner of the most recently completed access
//   grant      : winner this cycle (meaningful only when valid = 1)
//   valid      : at least one request present
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output grant_e     grant,
  output logic       valid
);

  // On contention the requester that did not get the previous access wins;
  // a lone requester always wins immediately.
  always_comb begin
    valid = |req;
    grant = GRANT_LOADER;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_LOADER) ? GRANT_CORE : GRANT_LOADER;
    end else if (req[1]) begin
      grant = GRANT_CORE;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Single-port scheduler in front of the cache_memory data port. Shares the
// port between the boot-time program loader (write only) and the pipeline
// core (load/store) using a grant/issue/wait/done FSM with a watchdog.
//
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   boot_done          : 0 = loader phase (core ignored), 1 = core phase
//   ld_req/addr/wdata  : loader write request, held until ld_ack
//   ld_ack             : one-cycle loader completion pulse
//   cr_req/we/addr/wdata : core request (we=1 store), held until cr_ack
//   cr_rdata           : registered load data, updated on core load completion
//   cr_ack             : one-cycle core completion pulse
//   cr_stall           : cr_req & ~cr_ack
//   mem_sig, mem_read_or_write, mem_addr, mem_wdata : to cache_memory
//   mem_rdata, mem_finish : from cache_memory
//   busy               : FSM not in IDLE
//   tmo_err            : sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              boot_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              cr_req,
  input  logic              cr_we,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [DATA_W-1:0] cr_wdata,
  output logic [DATA_W-1:0] cr_rdata,
  output logic              cr_ack,
  output logic              cr_stall,
  output logic              mem_sig,
  output logic              mem_read_or_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_finish,
  output logic              busy,
  output logic              tmo_err
);

  state_e           state;
  grant_e           last_grant;
  grant_e           cur_grant;
  grant_e           arb_grant;
  logic             arb_valid;
  logic [1:0]       req_vec;
  logic [TMO_W-1:0] watchdog;
  logic [TMO_W-1:0] wd_next;
  logic             wd_expired;
  logic             core_load;

  // The core is only eligible once boot has finished.
  assign req_vec = {cr_req & boot_done, ld_req};

  rr_arb2 u_arb (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign cr_stall = cr_req & ~cr_ack;

  // The loader never reads, so a read on the port always belongs to the core.
  assign core_load = (cur_grant == GRANT_CORE) && (mem_read_or_write == MEM_READ);

  // wd_next counts WAIT cycles including the current one; the access is
  // abandoned in the WAIT cycle where that count reaches all-ones.
  assign wd_next    = watchdog + {{(TMO_W-1){1'b0}}, 1'b1};
  assign wd_expired = &wd_next;

  // Main FSM. All port-facing outputs are registered so that mem_sig rises
  // the cycle after a request is granted and acks land the cycle after
  // mem_finish (or the timeout).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= ST_IDLE;
      mem_sig           <= 1'b0;
      mem_read_or_write <= MEM_READ;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      ld_ack            <= 1'b0;
      cr_ack            <= 1'b0;
      cr_rdata          <= '0;
      busy              <= 1'b0;
      tmo_err           <= 1'b0;
      last_grant        <= GRANT_LOADER;
      cur_grant         <= GRANT_LOADER;
      watchdog          <= '0;
    end else begin
      ld_ack <= 1'b0;
      cr_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            cur_grant <= arb_grant;
            mem_sig   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
            if (arb_grant == GRANT_CORE) begin
              mem_addr          <= cr_addr;
              mem_wdata         <= cr_wdata;
              mem_read_or_write <= cr_we ? MEM_WRITE : MEM_READ;
            end else begin
              mem_addr          <= ld_addr;
              mem_wdata         <= ld_wdata;
              mem_read_or_write <= MEM_WRITE;
            end
          end
        end

        ST_ISSUE: begin
          watchdog <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mem_finish) begin
            if (core_load) begin
              cr_rdata <= mem_rdata;
            end
            mem_sig <= 1'b0;
            ld_ack  <= (cur_grant == GRANT_LOADER);
            cr_ack  <= (cur_grant == GRANT_CORE);
            state   <= ST_DONE;
          end else if (wd_expired) begin
            if (core_load) begin
              cr_rdata <= DATA_W'(TMO_DATA);
            end
            tmo_err  <= 1'b1;
            watchdog <= wd_next;
            mem_sig  <= 1'b0;
            ld_ack   <= (cur_grant == GRANT_LOADER);
            cr_ack   <= (cur_grant == GRANT_CORE);
            state    <= ST_DONE;
          end else begin
            watchdog <= wd_next;
          end
        end

        ST_DONE: begin
          last_grant <= cur_grant;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed self-checking bench for dmem_port_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        boot_done = 1'b0;
  logic        ld_req = 1'b0;
  logic [26:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_ack;
  logic        cr_req = 1'b0;
  logic        cr_we = 1'b0;
  logic [26:0] cr_addr = '0;
  logic [31:0] cr_wdata = '0;
  logic [31:0] cr_rdata;
  logic        cr_ack;
  logic        cr_stall;
  logic        mem_sig;
  logic        mem_read_or_write;
  logic [26:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_finish = 1'b0;
  logic        busy;
  logic        tmo_err;

  int tests_run = 0;
  int tests_failed = 0;

  dmem_port_arbiter #(.ADDR_W(27), .DATA_W(32), .TMO_W(16)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .boot_done         (boot_done),
    .ld_req            (ld_req),
    .ld_addr           (ld_addr),
    .ld_wdata          (ld_wdata),
    .ld_ack            (ld_ack),
    .cr_req            (cr_req),
    .cr_we             (cr_we),
    .cr_addr           (cr_addr),
    .cr_wdata          (cr_wdata),
    .cr_rdata          (cr_rdata),
    .cr_ack            (cr_ack),
    .cr_stall          (cr_stall),
    .mem_sig           (mem_sig),
    .mem_read_or_write (mem_read_or_write),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_finish        (mem_finish),
    .busy              (busy),
    .tmo_err           (tmo_err)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives both requester interfaces at once.
  task automatic applyStimulus(input logic l_req, input logic [26:0] l_addr,
                               input logic [31:0] l_data, input logic c_req,
                               input logic c_we, input logic [26:0] c_addr,
                               input logic [31:0] c_data);
    ld_req   = l_req;
    ld_addr  = l_addr;
    ld_wdata = l_data;
    cr_req   = c_req;
    cr_we    = c_we;
    cr_addr  = c_addr;
    cr_wdata = c_data;
  endtask

  // Waits (bounded) until mem_sig is observed high.
  task automatic waitMemSig(input string tag);
    int n = 0;
    while (mem_sig !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_mem_sig"}, {63'd0, mem_sig}, 64'd1);
  endtask

  // Called on the cycle mem_sig is first seen high. Holds mem_finish low for
  // d cycles (checking no ack appears), pulses it for one cycle and returns
  // on the cycle where the ack is expected.
  task automatic completeAccess(input string tag, input int d,
                                input logic [31:0] rdata);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      checkOutput({tag, "_no_early_ack"}, {62'd0, ld_ack, cr_ack}, 64'd0);
    end
    mem_finish = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_finish = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    int sig_cycles;
    int n;
    logic exp_core;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_sig", {63'd0, mem_sig}, 64'd0);
    checkOutput("rst_rw", {63'd0, mem_read_or_write}, 64'd1);
    checkOutput("rst_addr", {37'd0, mem_addr}, 64'd0);
    checkOutput("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    checkOutput("rst_acks", {62'd0, ld_ack, cr_ack}, 64'd0);
    checkOutput("rst_rdata", {32'd0, cr_rdata}, 64'd0);
    checkOutput("rst_busy_tmo", {62'd0, busy, tmo_err}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // ---- loader write during boot; core request must be ignored ----
    applyStimulus(1'b1, 27'h100, 32'hCAFE0001, 1'b1, 1'b0, 27'h999, 32'h0);
    @(negedge clk);
    checkOutput("ld_mem_sig", {63'd0, mem_sig}, 64'd1);
    checkOutput("ld_rw", {63'd0, mem_read_or_write}, 64'd0);
    checkOutput("ld_addr", {37'd0, mem_addr}, 64'h100);
    checkOutput("ld_wdata", {32'd0, mem_wdata}, 64'hCAFE0001);
    checkOutput("ld_busy", {63'd0, busy}, 64'd1);
    checkOutput("ld_cr_stall", {63'd0, cr_stall}, 64'd1);
    completeAccess("ld", 5, 32'h0);
    checkOutput("ld_ack", {63'd0, ld_ack}, 64'd1);
    checkOutput("ld_cr_ack_ignored", {63'd0, cr_ack}, 64'd0);
    checkOutput("ld_done_mem_sig", {63'd0, mem_sig}, 64'd0);
    ld_req = 1'b0;
    @(negedge clk);
    checkOutput("ld_ack_pulse", {63'd0, ld_ack}, 64'd0);
    checkOutput("ld_idle_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("boot_cr_ignored", {62'd0, busy, mem_sig}, 64'd0);
    checkOutput("boot_cr_stall", {63'd0, cr_stall}, 64'd1);

    // ---- core load after boot ----
    boot_done = 1'b1;
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b1, 1'b0, 27'h2000, 32'h0);
    @(negedge clk);
    checkOutput("cl_mem_sig", {63'd0, mem_sig}, 64'd1);
    checkOutput("cl_rw", {63'd0, mem_read_or_write}, 64'd1);
    checkOutput("cl_addr", {37'd0, mem_addr}, 64'h2000);
    checkOutput("cl_stall", {63'd0, cr_stall}, 64'd1);
    completeAccess("cl", 1, 32'h12345678);
    checkOutput("cl_ack", {62'd0, cr_ack, ld_ack}, 64'd2);
    checkOutput("cl_rdata", {32'd0, cr_rdata}, 64'h12345678);
    checkOutput("cl_stall_ack", {63'd0, cr_stall}, 64'd0);
    cr_req = 1'b0;
    @(negedge clk);
    checkOutput("cl_ack_pulse", {63'd0, cr_ack}, 64'd0);
    checkOutput("cl_rdata_hold", {32'd0, cr_rdata}, 64'h12345678);

    // ---- mem_finish while idle is ignored ----
    mem_finish = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    mem_finish = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("idle_fin_state", {61'd0, busy, mem_sig, ld_ack | cr_ack}, 64'd0);
    checkOutput("idle_fin_rdata", {32'd0, cr_rdata}, 64'h12345678);
    @(negedge clk);
    checkOutput("idle_fin_later", {61'd0, busy, mem_sig, ld_ack | cr_ack}, 64'd0);

    // ---- asynchronous reset during WAIT ----
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b1, 1'b1, 27'h6000, 32'h11112222);
    @(negedge clk);
    checkOutput("rw_mem_sig", {63'd0, mem_sig}, 64'd1);
    checkOutput("rw_rw", {63'd0, mem_read_or_write}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_mem_sig_busy", {62'd0, mem_sig, busy}, 64'd0);
    checkOutput("arst_rw", {63'd0, mem_read_or_write}, 64'd1);
    checkOutput("arst_addr_wdata", {5'd0, mem_addr, mem_wdata}, 64'd0);
    checkOutput("arst_rdata", {32'd0, cr_rdata}, 64'd0);
    checkOutput("arst_acks", {62'd0, ld_ack, cr_ack}, 64'd0);
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 27'h0, 32'h0);
    boot_done = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_quiet", {61'd0, busy, ld_ack, cr_ack}, 64'd0);
    end

    // ---- both held from the first boot_done cycle: CORE, LOADER, ... ----
    boot_done = 1'b1;
    applyStimulus(1'b1, 27'h400, 32'hB0B0B0B0, 1'b1, 1'b0, 27'h3000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_core = (i % 2 == 0);
      waitMemSig("rr");
      checkOutput("rr_rw", {63'd0, mem_read_or_write}, {63'd0, exp_core});
      checkOutput("rr_addr", {37'd0, mem_addr}, exp_core ? 64'h3000 : 64'h400);
      completeAccess("rr", 2, 32'hA0000000 + 32'(i));
      checkOutput("rr_acks", {62'd0, cr_ack, ld_ack},
                  exp_core ? 64'd2 : 64'd1);
      if (exp_core) begin
        checkOutput("rr_rdata", {32'd0, cr_rdata}, 64'hA0000000 + 64'(i));
      end
    end
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 27'h0, 32'h0);
    @(negedge clk);

    // ---- core store that never finishes: watchdog timeout ----
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b1, 1'b1, 27'h5000, 32'h55AA55AA);
    waitMemSig("tmo");
    checkOutput("tmo_wdata", {32'd0, mem_wdata}, 64'h55AA55AA);
    checkOutput("tmo_err_before", {63'd0, tmo_err}, 64'd0);
    sig_cycles = 1;
    n = 0;
    while (cr_ack !== 1'b1 && n < 70000) begin
      @(negedge clk);
      if (mem_sig === 1'b1) sig_cycles++;
      n++;
    end
    checkOutput("tmo_ack", {63'd0, cr_ack}, 64'd1);
    checkOutput("tmo_err_set", {63'd0, tmo_err}, 64'd1);
    checkOutput("tmo_sig_cycles", 64'(sig_cycles), 64'd65536);
    checkOutput("tmo_store_rdata", {32'd0, cr_rdata}, 64'hA0000002);
    cr_req = 1'b0;
    @(negedge clk);
    checkOutput("tmo_idle", {62'd0, busy, cr_ack}, 64'd0);

    // ---- next access still works, error stays sticky ----
    applyStimulus(1'b0, 27'h0, 32'h0, 1'b1, 1'b0, 27'h7000, 32'h0);
    waitMemSig("post_tmo");
    completeAccess("post_tmo", 1, 32'h0BADF00D);
    checkOutput("post_tmo_ack", {63'd0, cr_ack}, 64'd1);
    checkOutput("post_tmo_rdata", {32'd0, cr_rdata}, 64'h0BADF00D);
    checkOutput("post_tmo_err", {63'd0, tmo_err}, 64'd1);
    cr_req = 1'b0;
    @(negedge clk);
    checkOutput("post_tmo_idle", {62'd0, busy, cr_ack}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
